// File: rtl/countdown_timer_mmss_if.sv
// rtl/countdown_timer_mmss_if.sv - command and count bus of the mm:ss countdown timer
//
// Purpose: bundles the keypad-side commands and the display/alarm-side
// outputs of countdown_timer_mmss into one bus.
// Signals:
//   load, min_in[7:0], sec_in[7:0]   load request with BCD {tens, units} value
//   start, pause, cancel             run control commands
//   min_out[7:0], sec_out[7:0]       current BCD count
//   running                          high while counting
//   done                             one-cycle pulse on reaching 00:00
//   alarm                            held from 00:00 until cancel or load
//   load_err                         one-cycle pulse on a rejected load
// Modports: master drives commands (entry logic), slave is the timer.

interface countdown_timer_mmss_if;
  logic       load;
  logic [7:0] min_in;
  logic [7:0] sec_in;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [7:0] min_out;
  logic [7:0] sec_out;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  modport master (
    output load, min_in, sec_in, start, pause, cancel,
    input  min_out, sec_out, running, done, alarm, load_err
  );

  modport slave (
    input  load, min_in, sec_in, start, pause, cancel,
    output min_out, sec_out, running, done, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer_mmss.sv
// rtl/countdown_timer_mmss.sv - loadable BCD mm:ss down-counter that stops at 00:00
//
// Purpose: counts a loaded minutes:seconds value down once per TICK_DIV
// clock cycles, stops at 00:00, pulses done and holds alarm there.
// Ports:
//   clk    system clock, rising edge
//   clear  asynchronous active-low reset
//   bus    countdown_timer_mmss_if.slave (commands in, count/status out)
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   MAX_MIN   largest accepted minutes value (decimal)

module countdown_timer_mmss #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic                 clk,
  input  logic                 clear,
  countdown_timer_mmss_if.slave bus
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          load_err_q, load_err_d;

  // BCD decrement of one two-digit field; callers never pass 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end
    return {v[7:4] - 4'd1, 4'd9};
  endfunction

  // Load value validation
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic [7:0] min_dec;
  logic       load_valid, load_zero;

  assign min_t      = bus.min_in[7:4];
  assign min_u      = bus.min_in[3:0];
  assign sec_t      = bus.sec_in[7:4];
  assign sec_u      = bus.sec_in[3:0];
  assign min_dec    = {4'd0, min_t} * 8'd10 + {4'd0, min_u};
  assign load_valid = (min_t <= 4'd9) && (min_u <= 4'd9) && (sec_t <= 4'd5) &&
                      (sec_u <= 4'd9) && (32'(min_dec) <= MAX_MIN);
  assign load_zero  = (bus.min_in == 8'h00) && (bus.sec_in == 8'h00);

  // Only the highest-priority asserted command acts; a shadowed one is dropped.
  logic cmd_load, cmd_start, cmd_pause;

  assign cmd_load  = !bus.cancel && bus.load;
  assign cmd_start = !bus.cancel && !bus.load && bus.start;
  assign cmd_pause = !bus.cancel && !bus.load && !bus.start && bus.pause;

  // Count one second lower, borrowing seconds into minutes
  logic [7:0] dec_min, dec_sec;
  logic       dec_zero, tick;

  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q != 8'h00) begin
      dec_sec = bcd_dec(sec_q);
    end else if (min_q != 8'h00) begin
      dec_sec = 8'h59;
      dec_min = bcd_dec(min_q);
    end
  end

  assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  assign tick     = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      presc_q    <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  // Next-state logic: state, count and prescaler
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    if (bus.cancel) begin
      state_d = S_IDLE;
      min_d   = 8'h00;
      sec_d   = 8'h00;
      presc_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          // Pause wins over a coincident tick, which is then lost.
          if (cmd_pause) begin
            state_d = S_PAUSED;
          end else if (tick) begin
            presc_d = '0;
            min_d   = dec_min;
            sec_d   = dec_sec;
            if (dec_zero) begin
              state_d = S_DONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          if (cmd_load) begin
            if (load_valid) begin
              if (load_zero) begin
                state_d = S_IDLE;
                min_d   = 8'h00;
                sec_d   = 8'h00;
              end else begin
                state_d = S_ARMED;
                min_d   = bus.min_in;
                sec_d   = bus.sec_in;
              end
            end
          end else if (cmd_start && (state_q == S_ARMED || state_q == S_PAUSED)) begin
            state_d = S_RUN;
            // Resuming keeps the partial second already counted.
            if (state_q == S_ARMED) begin
              presc_d = '0;
            end
          end
        end
      endcase
    end
  end

  // Output logic: registered status derived from the coming state
  always_comb begin
    running_d  = (state_d == S_RUN);
    alarm_d    = (state_d == S_DONE);
    done_d     = (state_q == S_RUN) && (state_d == S_DONE);
    load_err_d = cmd_load && (state_q != S_RUN) && !load_valid;
  end

  assign bus.min_out  = min_q;
  assign bus.sec_out  = sec_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb/tb_countdown_timer_mmss.sv - self-checking bench for countdown_timer_mmss

module tb_countdown_timer_mmss;

  localparam int TD = 4;
  localparam int MAXM = 99;

  // Reference model modes
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

  logic clk;
  logic clear;
  int   checks;
  int   errors;
  int   done_seen;

  // Model state: remaining time kept as plain seconds
  int m_secs;
  int m_mode;
  int m_phase;
  bit m_done;
  bit m_err;

  countdown_timer_mmss_if bus_if ();

  countdown_timer_mmss #(.TICK_DIV(TD), .MAX_MIN(MAXM)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_secs  = 0;
    m_mode  = M_IDLE;
    m_phase = 0;
    m_done  = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input logic [7:0] mi,
                            input logic [7:0] si, input bit s, input bit p);
    int mt, mu, st, su;
    bit valid;
    m_done = 0;
    m_err  = 0;
    if (c) begin
      model_reset();
    end else if (m_mode == M_RUN) begin
      if (!l && !s && p) begin
        m_mode = M_PAUSED;
      end else begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_mode = M_DONE;
            m_done = 1;
          end
        end
      end
    end else if (l) begin
      mt = int'(mi[7:4]);
      mu = int'(mi[3:0]);
      st = int'(si[7:4]);
      su = int'(si[3:0]);
      valid = (mt <= 9) && (mu <= 9) && (st <= 5) && (su <= 9) && (mt * 10 + mu <= MAXM);
      if (valid) begin
        m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
        m_mode = (m_secs != 0) ? M_ARMED : M_IDLE;
      end else begin
        m_err = 1;
      end
    end else if (s && (m_mode == M_ARMED || m_mode == M_PAUSED)) begin
      if (m_mode == M_ARMED) m_phase = 0;
      m_mode = M_RUN;
    end
  endtask

  task automatic check_all();
    chk("min_out",  bus_if.min_out,  to_bcd(m_secs / 60));
    chk("sec_out",  bus_if.sec_out,  to_bcd(m_secs % 60));
    chk("running",  {7'd0, bus_if.running},  {7'd0, m_mode == M_RUN});
    chk("done",     {7'd0, bus_if.done},     {7'd0, m_done});
    chk("alarm",    {7'd0, bus_if.alarm},    {7'd0, m_mode == M_DONE});
    chk("load_err", {7'd0, bus_if.load_err}, {7'd0, m_err});
  endtask

  task automatic step(input bit c, input bit l, input logic [7:0] mi,
                      input logic [7:0] si, input bit s, input bit p);
    bus_if.cancel = c;
    bus_if.load   = l;
    bus_if.min_in = mi;
    bus_if.sec_in = si;
    bus_if.start  = s;
    bus_if.pause  = p;
    @(posedge clk);
    #1;
    model_step(c, l, mi, si, s, p);
    check_all();
    if (bus_if.done === 1'b1) done_seen++;
    bus_if.cancel = 1'b0;
    bus_if.load   = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.pause  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic do_load(input logic [7:0] mi, input logic [7:0] si);
    step(0, 1, mi, si, 0, 0);
  endtask

  initial begin
    logic [7:0] rmi, rsi;
    bit rc, rl, rs, rp;
    checks = 0;
    errors = 0;
    done_seen = 0;
    model_reset();

    // Reset held while a load is requested
    clear         = 1'b0;
    bus_if.cancel = 1'b0;
    bus_if.load   = 1'b1;
    bus_if.min_in = 8'h05;
    bus_if.sec_in = 8'h00;
    bus_if.start  = 1'b0;
    bus_if.pause  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    bus_if.load = 1'b0;
    clear = 1'b1;
    idle(2);

    // Basic countdown 00:03
    done_seen = 0;
    do_load(8'h00, 8'h03);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(4);
    chk("basic_sec02", bus_if.sec_out, 8'h02);
    idle(4);
    chk("basic_sec01", bus_if.sec_out, 8'h01);
    idle(4);
    chk("basic_sec00", bus_if.sec_out, 8'h00);
    chk("basic_done", {7'd0, bus_if.done}, 8'h01);
    idle(1);
    chk("basic_done_gone", {7'd0, bus_if.done}, 8'h00);
    chk("basic_alarm", {7'd0, bus_if.alarm}, 8'h01);
    idle(32);
    chk("basic_hold_sec", bus_if.sec_out, 8'h00);
    chk("basic_hold_min", bus_if.min_out, 8'h00);
    chk("basic_done_count", 8'(done_seen), 8'd1);

    // Borrow across minutes
    step(1, 0, 8'h00, 8'h00, 0, 0);
    done_seen = 0;
    do_load(8'h01, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(4);
    chk("borrow_min", bus_if.min_out, 8'h00);
    chk("borrow_sec", bus_if.sec_out, 8'h59);
    idle(59 * 4);
    chk("borrow_end_sec", bus_if.sec_out, 8'h00);
    chk("borrow_done_count", 8'(done_seen), 8'd1);
    do_load(8'h10, 8'h00);
    chk("load_clears_alarm", {7'd0, bus_if.alarm}, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(4);
    chk("ten_min_min", bus_if.min_out, 8'h09);
    chk("ten_min_sec", bus_if.sec_out, 8'h59);

    // Pause and resume with preserved prescaler
    step(1, 0, 8'h00, 8'h00, 0, 0);
    do_load(8'h00, 8'h10);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(4);
    chk("pause_first_tick", bus_if.sec_out, 8'h09);
    idle(2);
    step(0, 0, 8'h00, 8'h00, 0, 1);
    idle(20);
    chk("pause_hold_sec", bus_if.sec_out, 8'h09);
    chk("pause_running", {7'd0, bus_if.running}, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(1);
    chk("resume_not_yet", bus_if.sec_out, 8'h09);
    idle(1);
    chk("resume_tick", bus_if.sec_out, 8'h08);

    // Illegal loads
    step(1, 0, 8'h00, 8'h00, 0, 0);
    do_load(8'h00, 8'h10);
    do_load(8'h00, 8'h60);
    chk("bad_sec_err", {7'd0, bus_if.load_err}, 8'h01);
    chk("bad_sec_keep", bus_if.sec_out, 8'h10);
    idle(1);
    chk("err_one_cycle", {7'd0, bus_if.load_err}, 8'h00);
    do_load(8'h1A, 8'h00);
    chk("bad_min_err", {7'd0, bus_if.load_err}, 8'h01);
    chk("bad_min_keep", bus_if.min_out, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    do_load(8'h05, 8'h30);
    chk("run_load_err", {7'd0, bus_if.load_err}, 8'h00);
    chk("run_load_keep_min", bus_if.min_out, 8'h00);
    chk("run_load_keep_sec", bus_if.sec_out, 8'h10);

    // Priority and zero start
    step(1, 1, 8'h05, 8'h00, 0, 0);
    chk("cancel_wins_min", bus_if.min_out, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    chk("zero_no_start", {7'd0, bus_if.running}, 8'h00);
    do_load(8'h00, 8'h01);
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(4);
    chk("alarm_set", {7'd0, bus_if.alarm}, 8'h01);
    do_load(8'h00, 8'h02);
    chk("alarm_cleared", {7'd0, bus_if.alarm}, 8'h00);

    // Reset asserted mid-run
    step(0, 0, 8'h00, 8'h00, 1, 0);
    idle(3);
    #3;
    clear = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    clear = 1'b1;
    idle(1);

    // Randomized command traffic
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom_range(0, 63) == 0);
      rl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rmi = 8'($urandom);
        rsi = 8'($urandom);
      end else begin
        rmi = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
        rsi = to_bcd(int'($urandom_range(0, 12)));
      end
      step(rc, rl, rmi, rsi, rs, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_mmss.md
Name: countdown_timer_mmss

Overview:
- Loadable BCD minutes:seconds down-counter for the timer-control path. It is the counting-down counterpart of the saturating up-counter.
- Counts one-second periods from an internal prescaler and stops at 00:00 (non-recycling). Raises a done pulse and a latched alarm at 00:00.
- Sits between keypad/entry logic (load, start, pause, cancel) and the display driver and magnetron/alarm control.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick. Must be ≥2. Benches use 4.
- MAX_MIN, 99: largest accepted minutes value, in decimal.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- load  in  1  load min_in/sec_in. Level-sampled each cycle.
- min_in  in  8  BCD minutes, {tens, units}.
- sec_in  in  8  BCD seconds, {tens, units}.
- start  in  1  begin or resume counting.
- pause  in  1  hold the count.
- cancel  in  1  abort: zero the count, clear the alarm.
- min_out  out  8  current BCD minutes.
- sec_out  out  8  current BCD seconds.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching 00:00.
- alarm  out  1  high from reaching 00:00 until cancel or load.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (clear=0), asynchronous: state IDLE; min_out=00, sec_out=00, prescaler=0; running, done, alarm and load_err all 0.
- States:
  - IDLE: count is 00:00.
  - ARMED: count nonzero, not counting.
  - RUN: counting.
  - PAUSED: count held.
  - DONE: count reached 00:00, alarm on.
- Command priority within one cycle: cancel > load > start > pause. Only the highest-priority asserted command acts.
- cancel (any state): next cycle IDLE, 00:00, alarm=0, prescaler=0.
- load, legal only in IDLE, ARMED, PAUSED and DONE; ignored in RUN:
  - Validity: every digit ≤9, sec tens ≤5, minutes ≤ MAX_MIN.
  - Valid and nonzero: count loads, state ARMED, alarm cleared.
  - Valid and zero: state IDLE, count 00:00, alarm cleared.
  - Invalid: count and state unchanged; load_err=1 for exactly the next cycle.
- start:
  - From ARMED or PAUSED: enter RUN. From ARMED the prescaler is cleared; from PAUSED it keeps its value.
  - In IDLE, DONE or RUN: ignored. A zero count never starts.
- pause in RUN: enter PAUSED; count and prescaler frozen. Ignored elsewhere.
- Prescaler:
  - In RUN, increments every cycle.
  - At TICK_DIV-1 it wraps to 0 and generates a tick in that cycle.
  - First decrement happens TICK_DIV cycles after the start edge.
- Decrement on tick, BCD arithmetic with no binary intermediate:
  - Seconds units >0: units-1.
  - Units =0, seconds tens >0: tens-1, units=9.
  - Seconds =00 and minutes >0: seconds=59, minutes decrement by the same BCD rule.
- Reaching 00:00:
  - On the tick that produces 00:00, the registers show 00:00 next cycle.
  - In that same next cycle: state DONE, done=1 for one cycle only, alarm=1, running=0.
  - No further decrement; there is never a wrap to 99:59.
- running is a registered function of state: 1 exactly when state is RUN.
- A pause or cancel in the same cycle as a tick takes priority: the tick is discarded.
- Reset asserted mid-RUN: immediate return to the reset values. No done pulse is generated.

Test Plan (TICK_DIV=4):
- Reset: clear=0 with load=1, min_in=8'h05 → all outputs 0, state IDLE. Release clear → outputs stay 0.
- Basic countdown: load 00:03, start → sec_out 02, 01, 00 at 4-cycle spacing. done high exactly one cycle with sec_out=00; alarm stays high; 8 further ticks leave 00:00.
- Borrow: load 01:00, start → after 1 tick 00:59; after 60 ticks 00:00 with done pulse. Load 10:00 → first tick gives 09:59.
- Pause/resume: load 00:10, start, pause 2 cycles after the first tick → value 09 holds for 20 cycles with running=0. Resume → next decrement 2 cycles later (prescaler preserved).
- Illegal loads: sec_in=8'h60, min_in=8'h1A, and a load during RUN → load_err pulses for the first two; count unchanged in all three cases.
- Priority and zero start: cancel+load same cycle → 00:00, IDLE. Start with 00:00 → running stays 0. Load while alarm=1 → alarm clears.
